// File: rtl/rom_burst_reader.sv
// Burst read initiator: drives ROM cs/addr for a run of words, streams registered data out.
// Latency: start -> mem_cs/mem_addr after 1 edge, first out_valid after 2 edges; 1 word/cycle.
// Backpressure: out_valid && !out_ready holds out_data/out_last/mem_addr and suspends fetching.
module rom_burst_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              mem_cs,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  // A burst never needs more than one pass over the whole address space.
  localparam int unsigned MAX_LEN = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  fetch_left;
  logic [LEN_W-1:0]  beat_left;
  logic [LEN_W-1:0]  len_clamped;
  logic              load;
  logic              handshake;

  // Clamp the requested length, then qualify fetches and stream handshakes.
  always_comb begin
    len_clamped = length;
    if (length > LEN_W'(MAX_LEN)) begin
      len_clamped = LEN_W'(MAX_LEN);
    end
    handshake = out_valid && out_ready;
    // A fetch happens only when the output register is free or being drained this cycle.
    load = (state == RUN) && (fetch_left != '0) && (!out_valid || out_ready);
  end

  // Burst control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_cs     <= 1'b0;
      mem_addr   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      fetch_left <= '0;
      beat_left  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          // FIN lasts one cycle but accepts a new command just like IDLE.
          state  <= IDLE;
          busy   <= 1'b0;
          mem_cs <= 1'b0;
          if (start) begin
            if (length == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state      <= RUN;
              busy       <= 1'b1;
              mem_cs     <= 1'b1;
              mem_addr   <= start_addr;
              fetch_left <= len_clamped;
              beat_left  <= len_clamped;
            end
          end
        end
        RUN: begin
          if (load) begin
            out_data   <= mem_data;
            out_valid  <= 1'b1;
            out_last   <= (fetch_left == LEN_W'(1));
            mem_addr   <= mem_addr + ADDR_W'(1);
            fetch_left <= fetch_left - LEN_W'(1);
            // Chip select drops together with the final fetch.
            mem_cs     <= (fetch_left != LEN_W'(1));
          end else if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
          if (handshake) begin
            beat_left <= beat_left - LEN_W'(1);
            if (out_last) begin
              state  <= FIN;
              busy   <= 1'b0;
              done   <= 1'b1;
              mem_cs <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_cs <= 1'b0;
        end
      endcase
    end
  end

endmodule
